// File: rtl/pc_sequencer.sv
// Program counter and flow controller for the 9-bit CPU: sequential fetch,
// relative branch, long jump, call/return through a small hardware stack, halt.
module pc_sequencer #(
  parameter int                PC_W        = 10,
  parameter int                STACK_DEPTH = 4,
  parameter logic [PC_W-1:0]   START_ADDR  = '0,
  localparam int               DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            op_br,
  input  logic            br_cond,
  input  logic [7:0]      br_off,
  input  logic            op_jmp,
  input  logic [PC_W-1:0] jmp_tgt,
  input  logic            op_call,
  input  logic [PC_W-1:0] call_tgt,
  input  logic            op_ret,
  input  logic            op_halt,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            done,
  output logic            stack_err,
  output logic [DW-1:0]   depth
);

  localparam int          SW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [DW-1:0]   depth_nxt;
  logic            push;

  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_ext;
  logic [SW-1:0]   push_idx;
  logic [SW-1:0]   pop_idx;

  assign pc_inc   = pc + PC_W'(1);
  assign br_ext   = {{(PC_W-8){br_off[7]}}, br_off};
  // Entries live at [0 .. depth-1]; the top of stack is depth-1.
  assign push_idx = SW'(depth);
  assign pop_idx  = SW'(depth - DW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= START_ADDR;
      depth <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      depth <= depth_nxt;
    end
  end

  // Stack contents need no reset: depth alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    push      = 1'b0;
    case (state)
      IDLE, HALT, ERR: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          depth_nxt = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (op_halt) begin
            state_nxt = HALT;
          end else if (op_ret) begin
            if (depth == '0) begin
              state_nxt = ERR;
            end else begin
              pc_nxt    = stack[pop_idx];
              depth_nxt = depth - DW'(1);
            end
          end else if (op_call) begin
            // Overflow faults without touching the stack so it can be inspected.
            if (depth == FULL) begin
              state_nxt = ERR;
            end else begin
              push      = 1'b1;
              pc_nxt    = call_tgt;
              depth_nxt = depth + DW'(1);
            end
          end else if (op_jmp) begin
            pc_nxt = jmp_tgt;
          end else if (op_br && br_cond) begin
            pc_nxt = pc + br_ext;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_en  = (state == RUN) && !stall;
  assign done      = (state == HALT);
  assign stack_err = (state == ERR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table plus expected-output queue for pc_sequencer, with hand-written
// sequences for asynchronous reset mid-run and while halted.
module tb_pc_sequencer;

  localparam int NONE = 0, BRT = 1, BRF = 2, JMP = 3, CALL = 4, RET = 5, HALT = 6;

  typedef struct packed {
    logic [9:0] pc;
    logic       fe;
    logic       dn;
    logic       er;
    logic [2:0] dp;
  } out_t;

  typedef struct {
    string      name;
    logic       start;
    logic       stall;
    int         op;
    logic [9:0] arg;
    out_t       exp;
  } vec_t;

  logic       clk, rst_n, start, stall, op_br, br_cond, op_jmp, op_call, op_ret, op_halt;
  logic [7:0] br_off;
  logic [9:0] jmp_tgt, call_tgt, pc;
  logic       fetch_en, done, stack_err;
  logic [2:0] depth;

  int   total = 0;
  int   passed = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .op_br(op_br), .br_cond(br_cond), .br_off(br_off),
    .op_jmp(op_jmp), .jmp_tgt(jmp_tgt), .op_call(op_call), .call_tgt(call_tgt),
    .op_ret(op_ret), .op_halt(op_halt),
    .pc(pc), .fetch_en(fetch_en), .done(done), .stack_err(stack_err), .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic st, logic sl, int op, int arg,
                              int epc, logic efe, logic edn, logic eer, int edp);
    vec_t v;
    v.name   = n;
    v.start  = st;
    v.stall  = sl;
    v.op     = op;
    v.arg    = 10'(arg);
    v.exp.pc = 10'(epc);
    v.exp.fe = efe;
    v.exp.dn = edn;
    v.exp.er = eer;
    v.exp.dp = 3'(edp);
    return v;
  endfunction

  function automatic out_t expo(int epc, logic efe, logic edn, logic eer, int edp);
    out_t o;
    o.pc = 10'(epc);
    o.fe = efe;
    o.dn = edn;
    o.er = eer;
    o.dp = 3'(edp);
    return o;
  endfunction

  task automatic drive(input vec_t v);
    start    = v.start;
    stall    = v.stall;
    op_br    = (v.op == BRT) || (v.op == BRF);
    br_cond  = (v.op == BRT);
    br_off   = v.arg[7:0];
    op_jmp   = (v.op == JMP);
    jmp_tgt  = v.arg;
    op_call  = (v.op == CALL);
    call_tgt = v.arg;
    op_ret   = (v.op == RET);
    op_halt  = (v.op == HALT);
  endtask

  task automatic check(input string n);
    out_t got, e;
    got = {pc, fetch_en, done, stack_err, depth};
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry queued", n);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e)
      $display("FAIL %s: got pc=%0d fetch_en=%b done=%b stack_err=%b depth=%0d, want pc=%0d fetch_en=%b done=%b stack_err=%b depth=%0d",
               n, got.pc, got.fe, got.dn, got.er, got.dp, e.pc, e.fe, e.dn, e.er, e.dp);
    else
      passed++;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    exp_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    check(v.name);
  endtask

  initial begin
    //                 name        st sl op    arg   pc   fe dn er dp
    vecs.push_back(mk("idle_ign",  0, 0, JMP,  5,    0,   0, 0, 0, 0));
    vecs.push_back(mk("start",     1, 0, NONE, 0,    0,   1, 0, 0, 0));
    vecs.push_back(mk("seq1",      0, 0, NONE, 0,    1,   1, 0, 0, 0));
    vecs.push_back(mk("seq2",      0, 0, NONE, 0,    2,   1, 0, 0, 0));
    vecs.push_back(mk("seq3",      0, 0, NONE, 0,    3,   1, 0, 0, 0));
    vecs.push_back(mk("seq4",      0, 0, NONE, 0,    4,   1, 0, 0, 0));
    vecs.push_back(mk("start_run", 1, 0, NONE, 0,    5,   1, 0, 0, 0));
    vecs.push_back(mk("jmp20",     0, 0, JMP,  20,   20,  1, 0, 0, 0));
    vecs.push_back(mk("br_back",   0, 0, BRT,  'hF6, 10,  1, 0, 0, 0));
    vecs.push_back(mk("jmp20b",    0, 0, JMP,  20,   20,  1, 0, 0, 0));
    vecs.push_back(mk("br_nt",     0, 0, BRF,  'hF6, 21,  1, 0, 0, 0));
    vecs.push_back(mk("br_fwd",    0, 0, BRT,  5,    26,  1, 0, 0, 0));
    vecs.push_back(mk("jmp30",     0, 0, JMP,  30,   30,  1, 0, 0, 0));
    vecs.push_back(mk("call100",   0, 0, CALL, 100,  100, 1, 0, 0, 1));
    vecs.push_back(mk("sub1",      0, 0, NONE, 0,    101, 1, 0, 0, 1));
    vecs.push_back(mk("sub2",      0, 0, NONE, 0,    102, 1, 0, 0, 1));
    vecs.push_back(mk("sub3",      0, 0, NONE, 0,    103, 1, 0, 0, 1));
    vecs.push_back(mk("ret31",     0, 0, RET,  0,    31,  1, 0, 0, 0));
    vecs.push_back(mk("call_n1",   0, 0, CALL, 200,  200, 1, 0, 0, 1));
    vecs.push_back(mk("call_n2",   0, 0, CALL, 300,  300, 1, 0, 0, 2));
    vecs.push_back(mk("call_n3",   0, 0, CALL, 400,  400, 1, 0, 0, 3));
    vecs.push_back(mk("call_n4",   0, 0, CALL, 500,  500, 1, 0, 0, 4));
    vecs.push_back(mk("overflow",  0, 0, CALL, 600,  500, 0, 0, 1, 4));
    vecs.push_back(mk("err_hold",  0, 0, NONE, 0,    500, 0, 0, 1, 4));
    vecs.push_back(mk("st_stall",  1, 1, NONE, 0,    0,   0, 0, 0, 0));
    vecs.push_back(mk("underflow", 0, 0, RET,  0,    0,   0, 0, 1, 0));
    vecs.push_back(mk("restart",   1, 0, NONE, 0,    0,   1, 0, 0, 0));
    vecs.push_back(mk("jmp7",      0, 0, JMP,  7,    7,   1, 0, 0, 0));
    vecs.push_back(mk("stall1",    0, 1, JMP,  50,   7,   0, 0, 0, 0));
    vecs.push_back(mk("stall2",    0, 1, JMP,  50,   7,   0, 0, 0, 0));
    vecs.push_back(mk("stall3",    0, 1, JMP,  50,   7,   0, 0, 0, 0));
    vecs.push_back(mk("unstall",   0, 0, NONE, 0,    8,   1, 0, 0, 0));
    vecs.push_back(mk("call40",    0, 0, CALL, 40,   40,  1, 0, 0, 1));
    vecs.push_back(mk("stall_ret", 0, 1, RET,  0,    40,  0, 0, 0, 1));
    vecs.push_back(mk("ret9",      0, 0, RET,  0,    9,   1, 0, 0, 0));
    vecs.push_back(mk("jmp1022",   0, 0, JMP,  1022, 1022,1, 0, 0, 0));
    vecs.push_back(mk("seq1023",   0, 0, NONE, 0,    1023,1, 0, 0, 0));
    vecs.push_back(mk("wrap0",     0, 0, NONE, 0,    0,   1, 0, 0, 0));
    vecs.push_back(mk("br_wrap",   0, 0, BRT,  'hF6, 1014,1, 0, 0, 0));
    vecs.push_back(mk("jmp1023",   0, 0, JMP,  1023, 1023,1, 0, 0, 0));
    vecs.push_back(mk("call_wrap", 0, 0, CALL, 5,    5,   1, 0, 0, 1));
    vecs.push_back(mk("ret_wrap",  0, 0, RET,  0,    0,   1, 0, 0, 0));
    vecs.push_back(mk("jmp50",     0, 0, JMP,  50,   50,  1, 0, 0, 0));
    vecs.push_back(mk("halt",      0, 0, HALT, 0,    50,  0, 1, 0, 0));
    vecs.push_back(mk("halt_hold", 0, 0, NONE, 0,    50,  0, 1, 0, 0));
    vecs.push_back(mk("halt_ign",  0, 0, JMP,  9,    50,  0, 1, 0, 0));
    vecs.push_back(mk("rst_halt",  1, 0, NONE, 0,    0,   1, 0, 0, 0));

    rst_n = 1'b0;
    drive(mk("z", 0, 0, NONE, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    exp_q.push_back(expo(0, 0, 0, 0, 0));
    check("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous reset in the middle of a running program.
    step(mk("jmp12", 0, 0, JMP, 12, 12, 1, 0, 0, 0));
    drive(mk("z", 0, 0, NONE, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(expo(0, 0, 0, 0, 0));
    check("rst_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("post_rst", 1, 0, NONE, 0, 0, 1, 0, 0, 0));
    step(mk("call_a",   0, 0, CALL, 77, 77, 1, 0, 0, 1));
    step(mk("halt2",    0, 0, HALT, 0, 77, 0, 1, 0, 1));
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(expo(0, 0, 0, 0, 0));
    check("rst_in_halt");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("idle_again", 0, 0, NONE, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/flow controller for the 9-bit CPU. Generates the 10-bit program counter that addresses instr_memory and resolves next-PC every cycle.
- Next-PC sources: sequential, relative branch, absolute long jump, subroutine call and return (with a hardware return stack), and program halt.
- Sits between the instruction decoder and instr_memory. The decoder supplies decoded flow-control requests; the sequencer owns the PC and the run/done handshake to the testbench or top level.

Parameters:
- PC_W, 10, program counter width; matches instr_memory address width.
- STACK_DEPTH, 4, number of return-address entries (2..8).
- START_ADDR, 0, PC value loaded on start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin or restart execution; sampled in IDLE, HALT or ERR.
- stall  input  1  hold PC and ignore all requests this cycle.
- op_br  input  1  conditional relative branch request.
- br_cond  input  1  branch condition; taken when op_br && br_cond.
- br_off  input  8  signed (two's complement) branch offset.
- op_jmp  input  1  absolute jump request.
- jmp_tgt  input  PC_W  jump target.
- op_call  input  1  subroutine call request.
- call_tgt  input  PC_W  subroutine entry address.
- op_ret  input  1  return-from-subroutine request.
- op_halt  input  1  program done.
- pc  output  PC_W  current fetch address.
- fetch_en  output  1  pc is a valid fetch this cycle.
- done  output  1  program completed normally.
- stack_err  output  1  return-stack overflow or underflow occurred.
- depth  output  $clog2(STACK_DEPTH+1)  current stack occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=START_ADDR, fetch_en=0, done=0, stack_err=0, depth=0.
  - Stack contents don't-care.
  - Reset asserted mid-program aborts immediately.
- States: IDLE, RUN, HALT, ERR.
- IDLE:
  - fetch_en=0; all op_* ignored.
  - start=1 -> RUN next cycle with pc=START_ADDR, depth=0.
- RUN:
  - fetch_en=1 while stall=0; fetch_en=0 while stall=1.
  - On each non-stalled edge, next PC uses priority halt > ret > call > jmp > branch > sequential.
  - The decoder asserts at most one request; the priority is defined for robustness only.
  - op_halt: pc holds; -> HALT; done=1 from the next cycle.
  - op_ret:
    - depth>0: pc=top entry, depth-1.
    - depth=0: -> ERR, pc holds.
  - op_call:
    - depth<STACK_DEPTH: push pc+1 (mod 2^PC_W), pc=call_tgt, depth+1.
    - depth=STACK_DEPTH: -> ERR, pc holds, stack unchanged.
  - op_jmp: pc=jmp_tgt.
  - op_br && br_cond: pc=pc+sext(br_off), mod 2^PC_W.
  - op_br && !br_cond: pc=pc+1.
  - No request: pc=pc+1; 2^PC_W-1 wraps to 0.
  - All updates take effect one cycle after the request; there are no delay slots.
  - stall=1: pc, depth and state hold; requests that cycle are discarded.
- HALT:
  - done=1 (level), fetch_en=0, pc holds.
  - start=1 -> RUN at START_ADDR; clears done, depth and stack_err.
- ERR:
  - stack_err=1 (level), fetch_en=0, done=0, pc holds the faulting address.
  - start=1 -> RUN at START_ADDR; clears stack_err and depth.
- start while in RUN: ignored.
- start and stall together: start takes effect; stall applies only in RUN.

Test Plan:
- Reset then start, 5 cycles with no requests -> pc 0,1,2,3,4; fetch_en=1; done=0.
- At pc=20, op_br=1, br_cond=1, br_off=8'hF6 (-10) -> pc=10 next cycle. Same request with br_cond=0 -> pc=21.
- At pc=30, op_call, call_tgt=100 -> pc=100, depth=1. After 3 sequential cycles (pc=103), op_ret -> pc=31, depth=0.
- Nested calls: 4 calls -> depth=4; 5th call -> ERR, stack_err=1, pc holds, fetch_en=0. Then start -> pc=0, stack_err=0. Separately, op_ret at depth=0 -> ERR.
- stall held 3 cycles at pc=7 with op_jmp asserted -> pc stays 7, jump discarded. Release stall -> pc=8. pc=1023 with no request -> pc=0.
- op_halt at pc=50 -> done=1 next cycle, pc=50, fetch_en=0. Assert rst_n=0 mid-RUN at pc=12 -> immediate IDLE, pc=0, done=0.
